mcb_wr_burst_gen: RTL and testbench
===================================

Name: mcb_wr_burst_gen

Overview:
- Write-side traffic generator for one MCB user port; sits directly upstream of the read-back checker on the same DDR region.
- Per burst: fills the MCB write-data FIFO with an alternating 128'hAA..AA / 128'h55..55 pattern, issues one write command, then pulses burst_done so the read side may start its read of the same address.
- Address advances by one burst per command and wraps at the top of the test region.

Parameters:
- BURST_LEN, 64, 128-bit words per burst; legal range 1..64.
- ADDR_INC, 30'h400, byte-address step per burst; must equal BURST_LEN*16.
- END_ADDR, 30'h0FFFFC00, last burst start address before wrap to 0.

Ports:
- clk  in  1  system/user clock of the MCB port.
- rst_n  in  1  asynchronous active-low reset.
- calib_done  in  1  MCB calibration complete; no activity while low.
- start  in  1  request one burst; sampled only in IDLE.
- wr_full  in  1  MCB write-data FIFO full.
- wr_underrun  in  1  MCB write underrun flag.
- cmd_full  in  1  MCB command FIFO full.
- wr_en  out  1  write-data FIFO push.
- wr_data  out  128  pattern word.
- wr_mask  out  16  byte mask; constant 0.
- cmd_en  out  1  command push, single cycle.
- cmd_instr  out  3  constant 3'b000 (write).
- cmd_addr  out  30  burst start byte address.
- cmd_bl  out  6  BURST_LEN-1.
- busy  out  1  high in any state but IDLE.
- burst_done  out  1  one-cycle pulse after command accepted.
- wr_error  out  1  sticky underrun indicator.

Behaviour:
- Reset (async assert, sync deassert by upstream): all outputs 0 except cmd_bl=BURST_LEN-1; state IDLE, word counter 0, address 0, pattern phase AA. Reset mid-burst abandons the burst. No partial command is issued.
- State machine:
  - IDLE: busy=0. Go to FILL when start=1 and calib_done=1; otherwise hold.
  - FILL: each cycle with wr_full=0, assert wr_en=1 with the current pattern word. Increment the word counter and toggle the phase (AA→55→AA…).
    - With wr_full=1, wr_en=0 and counter/phase hold.
    - Leave FILL after the push of word BURST_LEN-1 (counter reaches BURST_LEN) → CMD.
    - Exactly BURST_LEN pushes per burst; every burst starts at AA.
  - CMD: assert cmd_en=1 for exactly one cycle when cmd_full=0, with cmd_addr stable. While cmd_full=1, cmd_en=0 and wait. The cycle after cmd_en → DONE.
  - DONE: burst_done=1 for one cycle. Address update: if cmd_addr==END_ADDR then 0, else cmd_addr+ADDR_INC. Counter clears to 0, phase resets to AA. → IDLE.
- cmd_addr changes only in DONE; constant throughout FILL and CMD.
- wr_data is registered together with wr_en; it holds its last value when wr_en=0.
- Minimum burst latency with no backpressure, start-sample edge to burst_done high: BURST_LEN+2 cycles (FILL, CMD, DONE).
- start while busy=1: ignored, not queued.
- start held high: a new burst begins on the first IDLE cycle after DONE, giving back-to-back bursts.
- calib_done falling mid-burst: no effect; the burst completes.
- wr_error: set on any cycle with wr_underrun=1; cleared only by reset.
- Address arithmetic is 30-bit unsigned with no carry-out. Wrap is by equality compare only.

Test Plan:
- Reset, calib_done=1, start pulse, no backpressure → 64 wr_en cycles with data AA,55,AA,…,55 (word 63=55). Then one cmd_en with cmd_addr=0, cmd_bl=63, cmd_instr=0. burst_done exactly 66 cycles after start was sampled.
- wr_full toggling every other cycle during FILL → still exactly 64 pushes, pattern unbroken, no wr_en while wr_full=1.
- cmd_full held high 10 cycles at CMD entry → cmd_en stays low for those 10 cycles, then one single-cycle pulse; burst_done follows 1 cycle later.
- start held high, initial address preset by running to address END_ADDR-ADDR_INC → consecutive commands at 0x0FFFF800, 0x0FFFFC00, 0x00000000.
- Async rst_n asserted at word 20 of FILL → outputs 0 immediately. After release and start, 64 pushes begin with AA at cmd_addr=0.
- wr_underrun pulse for 1 cycle → wr_error=1 and remains 1 across later bursts until reset; calib_done=0 with start=1 → busy stays 0, no wr_en.

Source files
------------

// File: rtl/mcb_wr_burst_gen.sv
// Write-side traffic generator for one MCB user port: fills the write-data FIFO with an
// alternating AA/55 pattern, issues one write command, then pulses burst_done.
module mcb_wr_burst_gen #(
  parameter int unsigned BURST_LEN = 64,
  parameter logic [29:0] ADDR_INC  = 30'h400,
  parameter logic [29:0] END_ADDR  = 30'h0FFFFC00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         calib_done,
  input  logic         start,
  input  logic         wr_full,
  input  logic         wr_underrun,
  input  logic         cmd_full,
  output logic         wr_en,
  output logic [127:0] wr_data,
  output logic [15:0]  wr_mask,
  output logic         cmd_en,
  output logic [2:0]   cmd_instr,
  output logic [29:0]  cmd_addr,
  output logic [5:0]   cmd_bl,
  output logic         busy,
  output logic         burst_done,
  output logic         wr_error
);

  localparam int unsigned CntW = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(BURST_LEN - 1);
  localparam logic [127:0] PatAa = {16{8'hAA}};
  localparam logic [127:0] Pat55 = {16{8'h55}};

  typedef enum logic [1:0] {StIdle, StFill, StCmd, StDone} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           phase_q, phase_d;  // 0: next word is AA, 1: next word is 55
  logic [29:0]    addr_q, addr_d;
  logic           wr_en_q, wr_en_d;
  logic [127:0]   wr_data_q, wr_data_d;
  logic           cmd_en_q, cmd_en_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      cmd_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      cmd_en_q  <= cmd_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    cmd_en_d  = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q | wr_underrun;

    unique case (state_q)
      StIdle: begin
        if (start && calib_done) begin
          state_d = StFill;
        end
      end
      StFill: begin
        if (!wr_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = phase_q ? Pat55 : PatAa;
          phase_d   = ~phase_q;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d = StCmd;
          end
        end
      end
      StCmd: begin
        if (!cmd_full) begin
          cmd_en_d = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        // Wrap by equality only; the step is added without carry-out.
        addr_d  = (addr_q == END_ADDR) ? '0 : addr_q + ADDR_INC;
        cnt_d   = '0;
        phase_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign wr_mask    = '0;
  assign cmd_en     = cmd_en_q;
  assign cmd_instr  = 3'b000;
  assign cmd_addr   = addr_q;
  assign cmd_bl     = 6'(BURST_LEN - 1);
  assign busy       = (state_q != StIdle);
  assign burst_done = done_q;
  assign wr_error   = err_q;

endmodule

// File: tb/tb_mcb_wr_burst_gen.sv
// Directed bench: default-size instance for full bursts and reset, plus a small-burst instance
// for cycle-exact vector tables and address wrap.
module tb_mcb_wr_burst_gen;

  localparam logic [127:0] PAT_AA = {16{8'hAA}};
  localparam logic [127:0] PAT_55 = {16{8'h55}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic calib_done = 1'b0;
  logic start = 1'b0, wr_full = 1'b0, wr_underrun = 1'b0, cmd_full = 1'b0;
  logic s_start = 1'b0, s_wr_full = 1'b0, s_cmd_full = 1'b0, s_underrun = 1'b0;

  logic         wr_en, cmd_en, busy, burst_done, wr_error;
  logic [127:0] wr_data;
  logic [15:0]  wr_mask;
  logic [2:0]   cmd_instr;
  logic [29:0]  cmd_addr;
  logic [5:0]   cmd_bl;

  logic         s_wr_en, s_cmd_en, s_busy, s_burst_done, s_wr_error;
  logic [127:0] s_wr_data;
  logic [15:0]  s_wr_mask;
  logic [2:0]   s_cmd_instr;
  logic [29:0]  s_cmd_addr;
  logic [5:0]   s_cmd_bl;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mcb_wr_burst_gen dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .start(start), .wr_full(wr_full),
    .wr_underrun(wr_underrun), .cmd_full(cmd_full), .wr_en(wr_en), .wr_data(wr_data),
    .wr_mask(wr_mask), .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_addr(cmd_addr),
    .cmd_bl(cmd_bl), .busy(busy), .burst_done(burst_done), .wr_error(wr_error)
  );

  mcb_wr_burst_gen #(
    .BURST_LEN(4), .ADDR_INC(30'h40), .END_ADDR(30'hC0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .start(s_start),
    .wr_full(s_wr_full), .wr_underrun(s_underrun), .cmd_full(s_cmd_full),
    .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_mask(s_wr_mask), .cmd_en(s_cmd_en),
    .cmd_instr(s_cmd_instr), .cmd_addr(s_cmd_addr), .cmd_bl(s_cmd_bl), .busy(s_busy),
    .burst_done(s_burst_done), .wr_error(s_wr_error)
  );

  typedef struct {
    logic         start;
    logic         wf;
    logic         cf;
    logic         e_wr_en;
    logic [127:0] e_data;
    logic         e_cmd_en;
    logic         e_done;
    logic         e_busy;
    logic [29:0]  e_addr;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse on the default instance; monitors until burst_done or a cycle budget expires.
  task automatic run_burst(input bit toggle_full, input int cf_hold, input logic [29:0] exp_addr,
                           input int exp_done, input string tag);
    int pushes = 0, cmd_cnt = 0, cmd_cyc = -1, done_cyc = -1, cf_cnt = 0;
    int pat_err = 0, full_err = 0, ce_err = 0, addr_err = 0;
    logic prev_wf, prev_cf;
    logic [29:0] a_at_cmd = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, 128'(busy), 128'd1);
    for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
      wr_full  = toggle_full ? c[0] : 1'b0;
      cmd_full = (pushes == 64 && cf_cnt < cf_hold);
      if (cmd_full) cf_cnt++;
      prev_wf = wr_full;
      prev_cf = cmd_full;
      tick();
      if (wr_en) begin
        if (prev_wf) full_err++;
        if (wr_data !== ((pushes % 2) != 0 ? PAT_55 : PAT_AA)) pat_err++;
        pushes++;
      end
      if (cmd_en) begin
        if (prev_cf) ce_err++;
        cmd_cnt++;
        cmd_cyc  = c;
        a_at_cmd = cmd_addr;
      end
      if (burst_done) done_cyc = c;
      else if (cmd_addr !== exp_addr) addr_err++;
    end
    wr_full  = 1'b0;
    cmd_full = 1'b0;
    check({tag, " push count"}, 128'(pushes), 128'd64);
    check({tag, " pattern errors"}, 128'(pat_err), 128'd0);
    check({tag, " push after full"}, 128'(full_err), 128'd0);
    check({tag, " cmd_en while cmd_full"}, 128'(ce_err), 128'd0);
    check({tag, " cmd_en count"}, 128'(cmd_cnt), 128'd1);
    check({tag, " cmd_en cycle"}, 128'(cmd_cyc), 128'(exp_done - 1));
    check({tag, " burst_done cycle"}, 128'(done_cyc), 128'(exp_done));
    check({tag, " cmd_addr at cmd_en"}, 128'(a_at_cmd), 128'(exp_addr));
    check({tag, " cmd_addr unstable"}, 128'(addr_err), 128'd0);
    check({tag, " cmd_bl"}, 128'(cmd_bl), 128'd63);
    check({tag, " cmd_instr"}, 128'(cmd_instr), 128'd0);
    check({tag, " wr_mask"}, 128'(wr_mask), 128'd0);
    tick();
    check({tag, " burst_done single"}, 128'(burst_done), 128'd0);
    check({tag, " idle after burst"}, 128'(busy), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    int got;
    int pi;
    int cnt;
    logic [29:0] addrs[4];
    logic [29:0] exp_a[4];

    // start wf cf | wr_en data cmd_en done busy addr   (small instance, BURST_LEN=4)
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 128'h0,  1'b0, 1'b0, 1'b1, 30'h0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, PAT_AA, 1'b0, 1'b0, 1'b1, 30'h0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, PAT_AA, 1'b0, 1'b0, 1'b1, 30'h0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, PAT_55, 1'b0, 1'b0, 1'b1, 30'h0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, PAT_55, 1'b0, 1'b0, 1'b1, 30'h0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, PAT_AA, 1'b0, 1'b0, 1'b1, 30'h0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, PAT_55, 1'b0, 1'b0, 1'b1, 30'h0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, PAT_55, 1'b0, 1'b0, 1'b1, 30'h0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, PAT_55, 1'b0, 1'b0, 1'b1, 30'h0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, PAT_55, 1'b1, 1'b0, 1'b1, 30'h0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, PAT_55, 1'b0, 1'b1, 1'b0, 30'h40};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, PAT_55, 1'b0, 1'b0, 1'b1, 30'h40};
    exp_a[0] = 30'h40; exp_a[1] = 30'h80; exp_a[2] = 30'hC0; exp_a[3] = 30'h0;

    // Reset values
    #12;
    check("reset wr_en", 128'(wr_en), 128'd0);
    check("reset wr_data", wr_data, 128'd0);
    check("reset cmd_en", 128'(cmd_en), 128'd0);
    check("reset cmd_addr", 128'(cmd_addr), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset burst_done", 128'(burst_done), 128'd0);
    check("reset wr_error", 128'(wr_error), 128'd0);
    check("reset cmd_bl", 128'(cmd_bl), 128'd63);
    check("reset small cmd_bl", 128'(s_cmd_bl), 128'd3);
    rst_n = 1'b1;
    calib_done = 1'b1;
    tick();

    // Cycle-exact vectors on the small instance
    for (int i = 0; i < 12; i++) begin
      s_start    = vt[i].start;
      s_wr_full  = vt[i].wf;
      s_cmd_full = vt[i].cf;
      tick();
      check($sformatf("vec%0d wr_en", i), 128'(s_wr_en), 128'(vt[i].e_wr_en));
      check($sformatf("vec%0d wr_data", i), s_wr_data, vt[i].e_data);
      check($sformatf("vec%0d cmd_en", i), 128'(s_cmd_en), 128'(vt[i].e_cmd_en));
      check($sformatf("vec%0d burst_done", i), 128'(s_burst_done), 128'(vt[i].e_done));
      check($sformatf("vec%0d busy", i), 128'(s_busy), 128'(vt[i].e_busy));
      check($sformatf("vec%0d cmd_addr", i), 128'(s_cmd_addr), 128'(vt[i].e_addr));
    end
    s_wr_full  = 1'b0;
    s_cmd_full = 1'b0;

    // start held high: back-to-back bursts, address wraps after END_ADDR
    got = 0;
    pi = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      tick();
      if (s_wr_en) begin
        check($sformatf("b2b push%0d data", pi), s_wr_data, (pi % 2) != 0 ? PAT_55 : PAT_AA);
        pi++;
      end
      if (s_cmd_en) begin
        check($sformatf("b2b burst%0d pushes", got), 128'(pi), 128'd4);
        addrs[got] = s_cmd_addr;
        got++;
        pi = 0;
      end
    end
    s_start = 1'b0;
    check("b2b command count", 128'(got), 128'd4);
    for (int k = 0; k < 4 && k < got; k++) begin
      check($sformatf("b2b cmd%0d addr", k), 128'(addrs[k]), 128'(exp_a[k]));
    end

    // Default instance: plain burst, wr_full toggling, cmd_full backpressure
    run_burst(1'b0, 0, 30'h000, 66, "plain");
    run_burst(1'b1, 0, 30'h400, 130, "wr_full toggle");
    run_burst(1'b0, 10, 30'h800, 76, "cmd_full hold");
    check("addr after three bursts", 128'(cmd_addr), 128'h0C00);

    // Async reset in the middle of FILL
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 20; c++) begin
      tick();
      if (wr_en) cnt++;
    end
    check("pushes before reset", 128'(cnt), 128'd20);
    #2 rst_n = 1'b0;
    #1;
    check("midreset wr_en", 128'(wr_en), 128'd0);
    check("midreset wr_data", wr_data, 128'd0);
    check("midreset busy", 128'(busy), 128'd0);
    check("midreset cmd_addr", 128'(cmd_addr), 128'd0);
    check("midreset cmd_en", 128'(cmd_en), 128'd0);
    check("midreset cmd_bl", 128'(cmd_bl), 128'd63);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_burst(1'b0, 0, 30'h000, 66, "after reset");

    // calib_done low: start must be ignored
    calib_done = 1'b0;
    start = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy || wr_en) cnt++;
    end
    check("no activity without calib", 128'(cnt), 128'd0);
    start = 1'b0;
    calib_done = 1'b1;
    tick();

    // Sticky underrun flag
    check("wr_error before underrun", 128'(wr_error), 128'd0);
    wr_underrun = 1'b1;
    tick();
    wr_underrun = 1'b0;
    check("wr_error set", 128'(wr_error), 128'd1);
    run_burst(1'b0, 0, 30'h400, 66, "after underrun");
    check("wr_error sticky", 128'(wr_error), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("wr_error cleared by reset", 128'(wr_error), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
